dff_checker: RTL and testbench
==============================

# dff_checker

Synthesizable response checker for the single-bit D flip-flop family (`dff1` and its variants), the observing end of the flop test benches. The stimulus side drives `dut_reset` and `d`; this block watches those, together with the flop's `q` and `qb`, on the same clock. It keeps a one-cycle reference model and reports mismatches through a sticky flag, saturating counters and first-error capture. It is instantiated alongside the DUT in benches and in the sv2v equivalence regressions.

## Interface
- `CNT_W`, default 16: width of `cycle_count`, `err_count` and `first_err_cycle`; legal range 4..32.
- `STOP_AT_ERRS`, default 0: error count at which the checker halts; 0 means never halt.
- `clk`  input  1  shared clock with the DUT; all state updates on the rising edge.
- `reset`  input  1  checker reset; synchronous, active-high. This is not the DUT reset.
- `dut_reset`  input  1  DUT reset as driven by the stimulus.
- `d`  input  1  DUT data input.
- `q`  input  1  DUT output.
- `qb`  input  1  DUT inverted output.
- `armed`  output  1  the reference model holds a valid expectation this cycle.
- `err`  output  1  sticky mismatch flag.
- `err_count`  output  CNT_W  number of mismatching checked cycles; saturating.
- `cycle_count`  output  CNT_W  rising edges since `reset` deasserted; saturating.
- `first_err_cycle`  output  CNT_W  value of `cycle_count` at the first mismatch.
- `state`  output  2  FSM state (see package).

## Operation
- **Reference model.** On every edge where the FSM is not in HALT:
  - `exp_q <= dut_reset ? 0 : d`.
  - `exp_valid <= 1` if `dut_reset` = 1, or if `d` is 0 or 1.
  - In simulation, `d` of X or Z with `dut_reset` = 0 clears `exp_valid`.
- **FSM states.**
  - UNINIT: entered from reset. Stays here until `dut_reset` = 1 is sampled, then goes to CHECK. No comparisons are made before the DUT has been reset once.
  - CHECK: each edge where `exp_valid` = 1, compares the sampled `q` against `exp_q`.
  - HALT: entered when `STOP_AT_ERRS` != 0 and `err_count` reaches `STOP_AT_ERRS`. All registers freeze. Only `reset` leaves HALT.
- `armed` = (state == CHECK) && `exp_valid`.
- **Mismatch.** A mismatch in CHECK with `armed` = 1:
  - sets `err`;
  - increments `err_count`, saturating at 2^CNT_W−1;
  - if `err` was 0, loads `first_err_cycle` <= `cycle_count`.
- **Multiple failures in one cycle.** A `q` mismatch and a `qb` mismatch in the same cycle count as one error.
- **Counting.** `cycle_count` increments every non-HALT edge, including in UNINIT, and saturates at 2^CNT_W−1.
- **DUT reset mid-run.** `dut_reset` asserted while in CHECK keeps the checker in CHECK. The expectation becomes 0, so repeated DUT resets are checked, not ignored.
- **Checker reset mid-run.** `reset` = 1 at any time, including HALT, clears all state on that edge; the FSM returns to UNINIT.

## Timing
- Reset values:
  - `armed` = 0, `err` = 0;
  - `err_count` = 0, `cycle_count` = 0, `first_err_cycle` = 0;
  - `state` = UNINIT;
  - `exp_q` = 0, `exp_valid` = 0.
- **Check latency.** Stimulus sampled at edge k is checked against the `q` sampled at edge k+1, which is the flop output produced by edge k.
- **Output timing.** `err` and `err_count` update at edge k+1 and are visible after it. All outputs are registered; there are no combinational paths from input to output.
- **Entering CHECK.** The first checked cycle is the edge after the one that moves the FSM UNINIT→CHECK.
- **Entering HALT.** The FSM enters HALT on the same edge that `err_count` reaches `STOP_AT_ERRS`. That final error is recorded.

## Configuration
- Macro: `DFF_CHECKER_QB_EN`.
- **Defined:** a mismatch is also raised when `qb != ~q`, checked in the same armed cycles. It is counted once with any `q` mismatch in that cycle.
- **Undefined:** `qb` is ignored and the port remains present but unused.

## Structure
- Package `dff_checker_pkg` holds:
  - `typedef enum logic [1:0] {UNINIT=2'd0, CHECK=2'd1, HALT=2'd2} chk_state_t`;
  - constant `CHK_CNT_W_DEFAULT = 16`.
- Sub-module `sat_counter` (parameter `W`; ports `clk`, `reset`, `inc`, `hold`, `count`) is used for both `cycle_count` and `err_count`.

## Test plan
- Drive `reset` for 2 cycles, then `dut_reset` = 1 for 3 cycles, then `d` = 1 with a correct DUT → `armed` = 1 from the 2nd cycle after `dut_reset` is first sampled; `err` = 0 and `err_count` = 0 after 20 cycles.
- Force `q` = 0 for one cycle while `exp_q` = 1 at `cycle_count` = 7 → `err` = 1 and `err_count` = 1 on the next edge; `first_err_cycle` = 7 and stays 7 after later errors.
- Drive `d` = X with `dut_reset` = 0 for one cycle, with `q` = X on the next cycle → `armed` = 0 for that cycle; no error.
- `STOP_AT_ERRS` = 3 with `q` stuck at 0 and `d` = 1 → `state` = HALT after the 3rd error; `err_count` = 3 and `cycle_count` frozen. Then `reset` → all outputs return to 0 and `state` = UNINIT.
- `CNT_W` = 4, error every cycle for 20 cycles → `err_count` = 15 and `cycle_count` = 15, both saturated.
- With `DFF_CHECKER_QB_EN` defined, force `qb` = `q` = 1 while `exp_q` = 1 → exactly 1 error counted. Without the macro, the same stimulus gives 0 errors.

Source files
------------

// File: rtl/dff_checker_pkg.sv
// Shared types and defaults for the dff_checker response checker.
package dff_checker_pkg;

  typedef enum logic [1:0] {
    UNINIT = 2'd0,
    CHECK  = 2'd1,
    HALT   = 2'd2
  } chk_state_t;

  localparam int CHK_CNT_W_DEFAULT = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear and a freeze input.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         hold,
  output logic [W-1:0] count
);

  // NOTE: sequential state is always written with non-blocking assignments so every
  // flop samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !hold && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/dff_checker.sv
// Response checker for the single-bit D flip-flop family: one-cycle reference model,
// sticky error flag, saturating counters. Define DFF_CHECKER_QB_EN to also check qb == ~q.
module dff_checker
  import dff_checker_pkg::*;
#(
  parameter int          CNT_W        = CHK_CNT_W_DEFAULT,
  parameter int unsigned STOP_AT_ERRS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dut_reset,
  input  logic             d,
  input  logic             q,
  input  logic             qb,
  output logic             armed,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] first_err_cycle,
  output logic [1:0]       state
);

  chk_state_t st;
  logic       exp_q;
  logic       exp_valid;
  logic       d_known;
  logic       q_bad;
  logic       qb_bad;
  logic       mismatch;
  logic       halted;
  logic       halt_hit;
  logic [32:0] err_next;

  // NOTE: every always_comb variable gets a default first so no path can infer a latch.
  // The case compares with X-exact semantics in simulation, so an X/Z on d lands in
  // default; synthesis sees only 0/1 and reduces this to a constant 1.
  always_comb begin
    d_known = 1'b0;
    case (d)
      1'b0, 1'b1: d_known = 1'b1;
      default:    d_known = 1'b0;
    endcase
  end

  assign halted = (st == HALT);
  assign armed  = (st == CHECK) && exp_valid;
  assign q_bad  = (q != exp_q);

`ifdef DFF_CHECKER_QB_EN
  assign qb_bad = (qb == q);
`else
  logic unused_qb;
  assign unused_qb = qb;
  assign qb_bad    = 1'b0;
`endif

  // A q and qb failure in the same cycle is a single error.
  assign mismatch = armed && (q_bad || qb_bad);

  assign err_next = 33'(err_count) + 33'd1;
  assign halt_hit = (STOP_AT_ERRS != 0) && mismatch && (err_count != {CNT_W{1'b1}})
                    && (err_next == 33'(STOP_AT_ERRS));

  always_ff @(posedge clk) begin
    if (reset) begin
      st              <= UNINIT;
      exp_q           <= 1'b0;
      exp_valid       <= 1'b0;
      err             <= 1'b0;
      first_err_cycle <= '0;
    end else if (!halted) begin
      exp_q     <= dut_reset ? 1'b0 : d;
      exp_valid <= dut_reset | d_known;
      if (mismatch) begin
        err <= 1'b1;
        if (!err) begin
          first_err_cycle <= cycle_count;
        end
      end
      case (st)
        UNINIT:  if (dut_reset) st <= CHECK;
        CHECK:   if (halt_hit) st <= HALT;
        HALT:    st <= HALT;
        default: st <= UNINIT;
      endcase
    end
  end

  assign state = st;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (1'b1),
    .hold  (halted),
    .count (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mismatch),
    .hold  (halted),
    .count (err_count)
  );

endmodule

// File: tb/tb_dff_checker.sv
// Table-driven bench for dff_checker plus directed HALT, saturation, X and qb sequences.
module tb_dff_checker;
  import dff_checker_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, dut_reset = 1'b0, d = 1'b0;
  logic qf_en = 1'b0, qf_val = 1'b0, qbf_en = 1'b0, qbf_val = 1'b0;
  logic flop_q = 1'b0;
  logic q, qb;

  // Behavioural flop standing in for a correct DUT; the forces inject faults.
  always @(posedge clk) flop_q <= dut_reset ? 1'b0 : d;
  assign q  = qf_en  ? qf_val  : flop_q;
  assign qb = qbf_en ? qbf_val : ~q;

  logic        m_armed, m_err;
  logic [15:0] m_ec, m_cc, m_fe;
  logic [1:0]  m_st;
  logic        h_armed, h_err;
  logic [15:0] h_ec, h_cc, h_fe;
  logic [1:0]  h_st;
  logic        s_armed, s_err;
  logic [3:0]  s_ec, s_cc, s_fe;
  logic [1:0]  s_st;

  dff_checker u_main (
    .clk(clk), .reset(reset), .dut_reset(dut_reset), .d(d), .q(q), .qb(qb),
    .armed(m_armed), .err(m_err), .err_count(m_ec), .cycle_count(m_cc),
    .first_err_cycle(m_fe), .state(m_st)
  );

  dff_checker #(.STOP_AT_ERRS(3)) u_halt (
    .clk(clk), .reset(reset), .dut_reset(dut_reset), .d(d), .q(q), .qb(qb),
    .armed(h_armed), .err(h_err), .err_count(h_ec), .cycle_count(h_cc),
    .first_err_cycle(h_fe), .state(h_st)
  );

  dff_checker #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .dut_reset(dut_reset), .d(d), .q(q), .qb(qb),
    .armed(s_armed), .err(s_err), .err_count(s_ec), .cycle_count(s_cc),
    .first_err_cycle(s_fe), .state(s_st)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r, input logic dr, input logic dv,
                        input logic fe, input logic fv);
    reset = r; dut_reset = dr; d = dv; qf_en = fe; qf_val = fv;
  endtask

  typedef struct {
    logic       rst, dr, d, qf_en, qf_val;
    logic       armed, err;
    int         ec, cc, fe;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[17];

  localparam logic [1:0] S_UN = 2'(UNINIT);
  localparam logic [1:0] S_CK = 2'(CHECK);
  localparam logic [1:0] S_HT = 2'(HALT);

  initial begin
    logic xprobe;
    int   exp_qb_errs;

`ifdef DFF_CHECKER_QB_EN
    exp_qb_errs = 1;
`else
    exp_qb_errs = 0;
`endif

    //            rst dr  d   fen fv   arm err ec cc fe st
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0, 0, 0, 0, S_UN};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0, 0, 0, 0, S_UN};
    vecs[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0, 0, 1, 0, S_CK};
    vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0, 0, 2, 0, S_CK};
    vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0, 0, 3, 0, S_CK};
    vecs[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0, 0, 4, 0, S_CK};
    vecs[6]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0, 0, 5, 0, S_CK};
    vecs[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0, 0, 6, 0, S_CK};
    vecs[8]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0, 0, 7, 0, S_CK};
    vecs[9]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1,1'b1, 1, 8, 7, S_CK};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1, 1, 9, 7, S_CK};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1, 1,10, 7, S_CK};
    vecs[12] = '{1'b0,1'b0,1'b1,1'b1,1'b1, 1'b1,1'b1, 2,11, 7, S_CK};
    vecs[13] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1, 2,12, 7, S_CK};
    vecs[14] = '{1'b0,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b1, 2,13, 7, S_CK};
    vecs[15] = '{1'b0,1'b0,1'b1,1'b1,1'b1, 1'b1,1'b1, 3,14, 7, S_CK};
    vecs[16] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1, 3,15, 7, S_CK};

    #2;
    for (int i = 0; i < 17; i++) begin
      set_in(vecs[i].rst, vecs[i].dr, vecs[i].d, vecs[i].qf_en, vecs[i].qf_val);
      tick();
      check($sformatf("v%0d armed", i), 32'(m_armed), 32'(vecs[i].armed));
      check($sformatf("v%0d err", i),   32'(m_err),   32'(vecs[i].err));
      check($sformatf("v%0d err_count", i), 32'(m_ec), vecs[i].ec);
      check($sformatf("v%0d cycle_count", i), 32'(m_cc), vecs[i].cc);
      check($sformatf("v%0d first_err_cycle", i), 32'(m_fe), vecs[i].fe);
      check($sformatf("v%0d state", i), 32'(m_st), 32'(vecs[i].st));
    end

    // X on d only matters on a four-state simulator.
    xprobe = 1'bx;
    if ($isunknown(xprobe)) begin
      set_in(1'b0, 1'b0, 1'bx, 1'b0, 1'b0);
      tick();
      check("x armed", 32'(m_armed), 32'd0);
      set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'bx);
      tick();
      check("x err_count", 32'(m_ec), 32'd3);
      check("x rearmed", 32'(m_armed), 32'd1);
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      check("x after err_count", 32'(m_ec), 32'd3);
    end

    // qb equal to q while exp_q = 1.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    qf_en = 1'b1; qf_val = 1'b1; qbf_en = 1'b1; qbf_val = 1'b1;
    tick();
    check("qb err_count", 32'(m_ec), 32'(exp_qb_errs));
    qf_en = 1'b0; qbf_en = 1'b0;
    tick();
    check("qb err_count after", 32'(m_ec), 32'(exp_qb_errs));
    check("qb err", 32'(m_err), 32'(exp_qb_errs));

    // STOP_AT_ERRS = 3 with q stuck at 0.
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(); tick();
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(); tick(); tick();
    check("halt pre ec", 32'(h_ec), 32'd2);
    check("halt pre state", 32'(h_st), 32'(S_CK));
    tick();
    check("halt ec", 32'(h_ec), 32'd3);
    check("halt state", 32'(h_st), 32'(S_HT));
    check("halt cc", 32'(h_cc), 32'd5);
    check("halt first_err", 32'(h_fe), 32'd2);
    tick(); tick(); tick();
    check("halt frozen cc", 32'(h_cc), 32'd5);
    check("halt frozen ec", 32'(h_ec), 32'd3);
    check("halt frozen state", 32'(h_st), 32'(S_HT));
    check("halt armed", 32'(h_armed), 32'd0);
    reset = 1'b1;
    tick();
    check("halt rst armed", 32'(h_armed), 32'd0);
    check("halt rst err", 32'(h_err), 32'd0);
    check("halt rst ec", 32'(h_ec), 32'd0);
    check("halt rst cc", 32'(h_cc), 32'd0);
    check("halt rst first_err", 32'(h_fe), 32'd0);
    check("halt rst state", 32'(h_st), 32'(S_UN));

    // CNT_W = 4, error every cycle.
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++) tick();
    check("sat mid cc", 32'(s_cc), 32'd14);
    check("sat mid ec", 32'(s_ec), 32'd12);
    for (int i = 0; i < 7; i++) tick();
    check("sat cc", 32'(s_cc), 32'd15);
    check("sat ec", 32'(s_ec), 32'd15);
    check("sat err", 32'(s_err), 32'd1);
    check("sat first_err", 32'(s_fe), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
